// File: rtl/noc_pkg.sv
// Router-wide parameters and types shared by the switch allocator and its users.
package noc_pkg;

    localparam int PORT_NUM = 5;
    localparam int VC_NUM   = 2;

    localparam int PORT_W = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;
    localparam int VC_W   = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

    typedef logic [PORT_W-1:0] port_t;
    typedef logic [VC_W-1:0]   vc_t;

    // Per-output allocation state: free, or held by one (input, VC) for a packet.
    typedef enum logic {
        SA_IDLE   = 1'b0,
        SA_LOCKED = 1'b1
    } sa_state_t;

endpackage

// File: rtl/switch_allocator2crossbar.sv
// Crossbar select bundle: for each output port, the input port routed onto it.
interface switch_allocator2crossbar #(
    parameter int PORT_NUM = noc_pkg::PORT_NUM
);
    noc_pkg::port_t input_vc_sel [PORT_NUM];

    modport allocator (output input_vc_sel);
    modport crossbar  (input  input_vc_sel);
endinterface

// File: rtl/rr_arbiter.sv
// N-way arbiter. With SA_ROUND_ROBIN_EN defined it is round-robin with a
// pointer that advances past the winner only when 'update' is raised;
// otherwise it is plain fixed priority (lowest index wins, no state).
module rr_arbiter #(
    parameter int  N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          update,
    output logic [N-1:0]  gnt_onehot,
    output logic [IW-1:0] gnt_idx
);
`ifdef SA_ROUND_ROBIN_EN
    logic [IW-1:0] ptr_reg;
    logic [IW-1:0] ptr_next;
    logic [N-1:0]  req_rot;
    logic [IW:0]   sum;
    logic          found;

    // Rotate requests so the pointer sits at bit 0, take the first set bit,
    // then map the rotated position back to an absolute index.
    always_comb begin
        req_rot = N'({req, req} >> ptr_reg);
        found   = 1'b0;
        sum     = '0;
        gnt_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (!found && req_rot[i]) begin
                found = 1'b1;
                sum   = {1'b0, ptr_reg} + (IW+1)'(i);
                if (sum >= (IW+1)'(N)) begin
                    sum = sum - (IW+1)'(N);
                end
                gnt_idx = sum[IW-1:0];
            end
        end
        gnt_onehot = found ? (N'(1) << gnt_idx) : '0;
        ptr_next   = (gnt_idx == IW'(N-1)) ? '0 : gnt_idx + 1'b1;
    end

    // Pointer moves to winner+1 only when the winner's grant went through.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= '0;
        end else if (update && found) begin
            ptr_reg <= ptr_next;
        end
    end
`else
    logic unused_inputs;
    assign unused_inputs = ^{clk, rst_n, update};

    // Fixed priority: scan downwards so the lowest requesting index is kept.
    always_comb begin
        gnt_idx    = '0;
        gnt_onehot = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                gnt_idx = IW'(i);
            end
        end
        if (|req) begin
            gnt_onehot = N'(1) << gnt_idx;
        end
    end
`endif
endmodule

// File: rtl/switch_allocator.sv
// Two-stage wormhole switch allocator: stage 1 picks one VC per input,
// stage 2 picks one input per output; outputs stay locked to an (input, VC)
// from a granted head flit until its tail flit is granted.
// Optional feature: define SA_ROUND_ROBIN_EN for round-robin arbitration
// in both stages (fixed priority otherwise).
module switch_allocator
    import noc_pkg::*;
#(
    parameter int PORT_NUM = noc_pkg::PORT_NUM,
    parameter int VC_NUM   = noc_pkg::VC_NUM
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  req_i         [PORT_NUM][VC_NUM],
    input  port_t out_port_i    [PORT_NUM][VC_NUM],
    input  logic  tail_i        [PORT_NUM][VC_NUM],
    input  logic  credit_ok_i   [PORT_NUM],
    output logic  grant_valid_o [PORT_NUM],
    output vc_t   grant_vc_o    [PORT_NUM],
    output logic  out_valid_o   [PORT_NUM],
    switch_allocator2crossbar.allocator sa_if
);

    sa_state_t state_reg     [PORT_NUM];
    sa_state_t state_next    [PORT_NUM];
    port_t     owner_ip_reg  [PORT_NUM];
    port_t     owner_ip_next [PORT_NUM];
    vc_t       owner_vc_reg  [PORT_NUM];
    vc_t       owner_vc_next [PORT_NUM];

    logic [VC_NUM-1:0]   elig_mask    [PORT_NUM];
    logic [VC_NUM-1:0]   lock_mask    [PORT_NUM];
    logic [VC_NUM-1:0]   s1_req       [PORT_NUM];
    logic [VC_NUM-1:0]   s1_oh_unused [PORT_NUM];
    vc_t                 s1_vc        [PORT_NUM];
    logic                s1_valid     [PORT_NUM];
    port_t               s1_op        [PORT_NUM];
    logic [PORT_NUM-1:0] s2_req       [PORT_NUM];
    logic [PORT_NUM-1:0] s2_gnt       [PORT_NUM];
    port_t               s2_idx       [PORT_NUM];
    logic                in_gnt       [PORT_NUM];
    logic                out_gnt      [PORT_NUM];
    vc_t                 win_vc       [PORT_NUM];
    logic                win_tail     [PORT_NUM];

    // Eligibility per (input, VC); lock owners are split out so they win stage 1.
    always_comb begin
        port_t opi;
        logic  own;
        opi = '0;
        own = 1'b0;
        for (int ip = 0; ip < PORT_NUM; ip++) begin
            elig_mask[ip] = '0;
            lock_mask[ip] = '0;
            for (int v = 0; v < VC_NUM; v++) begin
                opi = out_port_i[ip][v];
                own = 1'b0;
                if (req_i[ip][v] && (int'(opi) < PORT_NUM)) begin
                    own = (state_reg[opi] == SA_LOCKED) &&
                          (owner_ip_reg[opi] == port_t'(ip)) &&
                          (owner_vc_reg[opi] == vc_t'(v));
                    if (credit_ok_i[opi] && ((state_reg[opi] == SA_IDLE) || own)) begin
                        elig_mask[ip][v] = 1'b1;
                        lock_mask[ip][v] = own;
                    end
                end
            end
            s1_req[ip] = (|lock_mask[ip]) ? lock_mask[ip] : elig_mask[ip];
        end
    end

    // Stage-1 results feed the per-output request vectors of stage 2.
    always_comb begin
        for (int ip = 0; ip < PORT_NUM; ip++) begin
            s1_valid[ip] = |s1_req[ip];
            s1_op[ip]    = out_port_i[ip][s1_vc[ip]];
        end
        for (int op = 0; op < PORT_NUM; op++) begin
            s2_req[op] = '0;
            for (int ip = 0; ip < PORT_NUM; ip++) begin
                s2_req[op][ip] = s1_valid[ip] && (s1_op[ip] == port_t'(op));
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < PORT_NUM; gi++) begin : g_arb
            rr_arbiter #(.N(VC_NUM)) u_s1_arb (
                .clk        (clk),
                .rst_n      (rst_n),
                .req        (s1_req[gi]),
                .update     (in_gnt[gi]),
                .gnt_onehot (s1_oh_unused[gi]),
                .gnt_idx    (s1_vc[gi])
            );

            rr_arbiter #(.N(PORT_NUM)) u_s2_arb (
                .clk        (clk),
                .rst_n      (rst_n),
                .req        (s2_req[gi]),
                .update     (out_gnt[gi]),
                .gnt_onehot (s2_gnt[gi]),
                .gnt_idx    (s2_idx[gi])
            );
        end
    endgenerate

    // Final grants: each output's stage-2 winner, folded back onto its input.
    always_comb begin
        for (int op = 0; op < PORT_NUM; op++) begin
            out_gnt[op]  = |s2_gnt[op];
            win_vc[op]   = s1_vc[s2_idx[op]];
            win_tail[op] = tail_i[s2_idx[op]][win_vc[op]];
        end
        for (int ip = 0; ip < PORT_NUM; ip++) begin
            in_gnt[ip] = 1'b0;
            for (int op = 0; op < PORT_NUM; op++) begin
                if (s2_gnt[op][ip]) begin
                    in_gnt[ip] = 1'b1;
                end
            end
        end
    end

    // Lock on a granted non-tail flit from idle; release on the owner's tail.
    always_comb begin
        for (int op = 0; op < PORT_NUM; op++) begin
            state_next[op]    = state_reg[op];
            owner_ip_next[op] = owner_ip_reg[op];
            owner_vc_next[op] = owner_vc_reg[op];
            if (out_gnt[op]) begin
                if ((state_reg[op] == SA_IDLE) && !win_tail[op]) begin
                    state_next[op]    = SA_LOCKED;
                    owner_ip_next[op] = s2_idx[op];
                    owner_vc_next[op] = win_vc[op];
                end else if ((state_reg[op] == SA_LOCKED) && win_tail[op]) begin
                    state_next[op] = SA_IDLE;
                end
            end
        end
    end

    // Per-output lock state; reset drops every lock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int op = 0; op < PORT_NUM; op++) begin
                state_reg[op]    <= SA_IDLE;
                owner_ip_reg[op] <= '0;
                owner_vc_reg[op] <= '0;
            end
        end else begin
            for (int op = 0; op < PORT_NUM; op++) begin
                state_reg[op]    <= state_next[op];
                owner_ip_reg[op] <= owner_ip_next[op];
                owner_vc_reg[op] <= owner_vc_next[op];
            end
        end
    end

    // Drive outputs, zeroed when idle and held at zero while reset is asserted.
    always_comb begin
        for (int p = 0; p < PORT_NUM; p++) begin
            grant_valid_o[p]      = 1'b0;
            grant_vc_o[p]         = '0;
            out_valid_o[p]        = 1'b0;
            sa_if.input_vc_sel[p] = '0;
            if (rst_n) begin
                grant_valid_o[p] = in_gnt[p];
                out_valid_o[p]   = out_gnt[p];
                if (in_gnt[p]) begin
                    grant_vc_o[p] = s1_vc[p];
                end
                if (out_gnt[p]) begin
                    sa_if.input_vc_sel[p] = s2_idx[p];
                end
            end
        end
    end

endmodule

// File: doc/switch_allocator.md
# switch_allocator

Per-cycle switch allocator for the router crossbar. For each output port it chooses one input port and one virtual channel (VC), and holds that choice for the whole packet (wormhole). It drives the crossbar's per-output input selection and tells each input block which VC to dequeue. It sits between the input blocks and the crossbar and connects to the crossbar through the `switch_allocator2crossbar` interface (allocator modport).

## Interface
- `PORT_NUM`, default `noc_pkg::PORT_NUM`: number of router ports; every port is both an input and an output.
- `VC_NUM`, default `noc_pkg::VC_NUM`: number of VCs per input port.
- `clk`  in  1  router clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, **asynchronous, active-low**.
- `req_i[PORT_NUM][VC_NUM]`  in  1  head-of-queue flit of the VC is valid.
- `out_port_i[PORT_NUM][VC_NUM]`  in  `port_t`  output port requested by that flit.
- `tail_i[PORT_NUM][VC_NUM]`  in  1  head-of-queue flit is a tail (single-flit packets assert it too).
- `credit_ok_i[PORT_NUM]`  in  1  downstream of the output port can accept one flit this cycle.
- `grant_valid_o[PORT_NUM]`  out  1  the input port pops one flit this cycle.
- `grant_vc_o[PORT_NUM]`  out  `vc_t`  VC to pop at that input.
- `sa_if.input_vc_sel[PORT_NUM]`  out  `port_t`  input port routed to each output (crossbar select).
- `out_valid_o[PORT_NUM]`  out  1  output port carries a valid flit this cycle.

## Operation
**Per-output state, `sa_state_t`**
- `SA_IDLE`: the output is free.
- `SA_LOCKED`: the output is held by a registered `(owner_ip, owner_vc)`.

**Eligibility.** A VC is eligible when all of the following hold:
- `req_i` is high.
- `out_port_i < PORT_NUM`. Requests to out-of-range ports are ignored and never granted.
- `credit_ok_i[out_port]` is high.
- The target output is `SA_IDLE`, or it is locked to exactly this `(ip, vc)`.

**Stage 1, per input.**
- Choose one eligible VC.
- A VC that owns a lock has priority over all others.
- Otherwise use the arbitration policy (see Configuration).

**Stage 2, per output.**
- Among the inputs whose stage-1 winner targets this output, choose one using the arbitration policy.
- A locked output can only see its owner, so no contention arises there.

**Grant.** A stage-2 winner produces, in the same cycle:
- `grant_valid_o[ip]=1` and `grant_vc_o[ip]=vc`.
- `input_vc_sel[op]=ip` and `out_valid_o[op]=1`.
- At most one grant per input and one per output per cycle.

**State transitions, on the clock edge**
- `SA_IDLE` → `SA_LOCKED` when a non-tail flit is granted; owner is set to the granted `(ip, vc)`.
- `SA_LOCKED` → `SA_IDLE` when the owner's tail flit is granted.
- Granting a head+tail flit leaves the output `SA_IDLE`.

**Boundary conditions**
- Owner's `req_i` low, or `credit_ok_i` low, while `SA_LOCKED`: the output stays locked and nothing is granted on it.
- Other inputs requesting a locked output are blocked. They still compete in stage 1 for other outputs.
- Default outputs when there is no grant: `input_vc_sel = 0`, `grant_vc_o = 0`, valids low.

## Timing
- **Latency:** allocation is combinational from inputs and registered state. The grant is valid in the same cycle as the request, so the crossbar forwards the flit in that cycle.
- **Pop handshake:** the input block pops on the rising edge at the end of any cycle with `grant_valid_o` high. It must present the next head flit in the following cycle.
- **Reset:** asserting `rst_n` low takes effect immediately (asynchronous).
  - All outputs are forced to 0 while `rst_n` is low.
  - All outputs `SA_IDLE`; all arbiter pointers 0.
- **Reset mid-packet:** locks are dropped. Upstream recovery is outside this block.

## Configuration
- `SA_ROUND_ROBIN_EN` defined:
  - Stage-1 (per input, over VCs) and stage-2 (per output, over inputs) arbiters are round-robin.
  - A pointer moves to winner+1 (mod N) only when that winner receives a final grant. Pointers do not move on stage-1-only wins.
- `SA_ROUND_ROBIN_EN` undefined:
  - Fixed priority; the lowest index wins.
  - No pointer registers exist.
  - Lock behaviour is unchanged.

## Structure
- **`noc_pkg`:**
  - `PORT_NUM`, `VC_NUM`.
  - `port_t` (`$clog2(PORT_NUM)` bits) and `vc_t` (`$clog2(VC_NUM)` bits).
  - `sa_state_t` enum {`SA_IDLE`, `SA_LOCKED`}.
- **Sub-module `rr_arbiter #(N)`:**
  - Inputs: `clk`, `rst_n`, `req[N]`, `update`.
  - Outputs: `gnt_onehot[N]`, `gnt_idx`.
  - Internal pointer register; reduces to fixed priority without `SA_ROUND_ROBIN_EN`.
  - Instantiated `PORT_NUM` times per stage.

## Test plan
- **Single-flit packet:** in0 vc1 head+tail to out2, credit ok.
  - Same cycle: `grant_valid_o[0]=1`, `grant_vc_o[0]=1`, `input_vc_sel[2]=0`, `out_valid_o[2]=1`.
  - Out2 remains `SA_IDLE`.
- **Wormhole lock:** 3-flit packet in1 vc0 to out3; in2 also requests out3 throughout.
  - in1 is granted on 3 consecutive cycles.
  - in2 is granted on the 4th cycle.
- **Credit stall:** `credit_ok_i[3]` low for 2 cycles mid-packet.
  - No grants on out3 during the stall, lock held.
  - Transfer resumes with the same owner.
- **Fairness (`SA_ROUND_ROBIN_EN`):** in0..in3 request out1 with single-flit packets continuously.
  - Grant order is 0,1,2,3,0.
  - Without the macro, in0 wins every cycle.
- **Reset mid-packet:** drive `rst_n` low after the head flit is granted.
  - All outputs are 0 immediately.
  - After release, out0 is `SA_IDLE` and a new requester is granted.
